// File: rtl/sap_main_memory.sv
// Main memory for the SAP datapath: clocked W-bus writes, combinational reads, zero-fill sweep
// after reset, and a front-panel programming port. Optional parity storage: SAP_MEM_PARITY_EN.
//
// state | meaning
// INIT  | zero-fill sweep, one word per cycle, busy=1
// RUN   | W-bus reads/writes at addr from MAR
// PROG  | front-panel deposits at prog_ptr
module sap_main_memory #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd_en,
   input  logic              wr_en,
   inout  wire  [DATA_W-1:0] wbus,
   input  logic              manual_mode,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic              prog_addr_ld,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              prog_strobe,
   output logic              busy,
   output logic [ADDR_W-1:0] prog_ptr,
   output logic              prog_wrap,
   output logic              bus_conflict,
   output logic              parity_err
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      INIT = 2'd0,
      RUN  = 2'd1,
      PROG = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] sweep_ptr;
   logic              s1, s2, s3;
   logic              dep;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;

   assign dep  = s2 & ~s3;
   assign busy = (state == INIT);

   // Only RUN with rd_en may drive the shared bus.
   assign wbus = (state == RUN && rd_en) ? mem[addr] : {DATA_W{1'bz}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT: if (sweep_ptr == LAST_ADDR) state_nxt = manual_mode ? PROG : RUN;
         RUN:  if (manual_mode)            state_nxt = PROG;
         PROG: if (!manual_mode)           state_nxt = RUN;
         default:                          state_nxt = INIT;
      endcase
   end

   // Single write port shared by sweep, bus and deposit paths.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = '0;
      mem_wd = '0;
      case (state)
         INIT: begin
            mem_we = 1'b1;
            mem_wa = sweep_ptr;
         end
         RUN: if (wr_en && !rd_en) begin
            mem_we = 1'b1;
            mem_wa = addr;
            mem_wd = wbus;
         end
         PROG: if (dep) begin
            mem_we = 1'b1;
            mem_wa = prog_ptr;
            mem_wd = prog_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sweep_ptr    <= '0;
         prog_ptr     <= '0;
         prog_wrap    <= 1'b0;
         bus_conflict <= 1'b0;
         s1           <= 1'b0;
         s2           <= 1'b0;
         s3           <= 1'b0;
      end else begin
         s1           <= prog_strobe;
         s2           <= s1;
         s3           <= s2;
         bus_conflict <= (state == RUN) && rd_en && wr_en;
         prog_wrap    <= 1'b0;
         if (state == INIT) sweep_ptr <= sweep_ptr + 1'b1;
         if (state == PROG) begin
            // A load on the deposit edge wins over the increment.
            if (prog_addr_ld) begin
               prog_ptr <= prog_addr;
            end else if (dep) begin
               prog_ptr  <= prog_ptr + 1'b1;
               prog_wrap <= (prog_ptr == LAST_ADDR);
            end
         end
      end
   end

`ifdef SAP_MEM_PARITY_EN
   logic mem_par [DEPTH];

   always @(posedge clk) begin
      if (mem_we) mem_par[mem_wa] <= ^mem_wd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= (state == RUN && rd_en && !wr_en) ? ((^mem[addr]) ^ mem_par[addr]) : 1'b0;
      end
   end

   task automatic flip_parity(input logic [ADDR_W-1:0] a);
      mem_par[a] <= ~mem_par[a];
   endtask
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sap_main_memory.sv
// Directed self-checking bench for sap_main_memory (DEPTH=16, DATA_W=8).
module tb_sap_main_memory;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] addr;
   logic       rd_en, wr_en;
   wire  [7:0] wbus;
   logic       manual_mode;
   logic [3:0] prog_addr;
   logic       prog_addr_ld;
   logic [7:0] prog_data;
   logic       prog_strobe;
   logic       busy;
   logic [3:0] prog_ptr;
   logic       prog_wrap, bus_conflict, parity_err;

   logic [7:0] tb_drv;
   logic       tb_drv_en;
   assign wbus = tb_drv_en ? tb_drv : 8'bzzzz_zzzz;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sap_main_memory #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .wbus(wbus),
      .manual_mode(manual_mode), .prog_addr(prog_addr), .prog_addr_ld(prog_addr_ld),
      .prog_data(prog_data), .prog_strobe(prog_strobe), .busy(busy), .prog_ptr(prog_ptr),
      .prog_wrap(prog_wrap), .bus_conflict(bus_conflict), .parity_err(parity_err)
   );

   task automatic count_busy(input string name);
      int cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         cnt++;
         @(negedge clk); #1;
      end
      checks++;
      if (cnt !== 16) begin
         failures++;
         $display("FAIL %s: busy cycles got %0d expected 16", name, cnt);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; addr = '0; rd_en = 0; wr_en = 0; manual_mode = 0;
      prog_addr = '0; prog_addr_ld = 0; prog_data = '0; prog_strobe = 0;
      tb_drv = '0; tb_drv_en = 0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({busy, prog_ptr, prog_wrap, bus_conflict, parity_err} !== 8'b1_0000_000) begin
         failures++;
         $display("FAIL reset_outputs: got busy=%b ptr=%0d wrap=%b conf=%b perr=%b expected 1 0 0 0 0",
                  busy, prog_ptr, prog_wrap, bus_conflict, parity_err);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      count_busy("sweep_len");
      @(negedge clk);
      rd_en = 1'b1;
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a); #1;
         checks++;
         if (wbus !== 8'h00) begin
            failures++;
            $display("FAIL zero_fill[%0d]: got %h expected 00", a, wbus);
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_run_rw;
      @(negedge clk);
      addr = 4'd3; tb_drv = 8'hA5; tb_drv_en = 1; wr_en = 1;
      @(negedge clk);
      wr_en = 0; tb_drv_en = 0; rd_en = 1; #1;
      checks++;
      if (wbus !== 8'hA5) begin
         failures++;
         $display("FAIL run_read: got %h expected a5", wbus);
      end
      rd_en = 0; tb_drv = 8'h3C; tb_drv_en = 1; #1;
      checks++;
      if (wbus !== 8'h3C) begin
         failures++;
         $display("FAIL run_release: got %h expected 3c (bus released)", wbus);
      end
      tb_drv_en = 0;
   endtask

   task automatic test_conflict;
      @(negedge clk);
      addr = 4'd3; rd_en = 1; wr_en = 1; #1;
      checks++;
      if (wbus !== 8'hA5 || bus_conflict !== 1'b0) begin
         failures++;
         $display("FAIL conflict_drive: got wbus=%h conf=%b expected a5 0", wbus, bus_conflict);
      end
      @(posedge clk); #1;
      checks++;
      if (bus_conflict !== 1'b1) begin
         failures++;
         $display("FAIL conflict_pulse: got %b expected 1", bus_conflict);
      end
      @(negedge clk);
      rd_en = 0; wr_en = 0;
      @(posedge clk); #1;
      checks++;
      if (bus_conflict !== 1'b0) begin
         failures++;
         $display("FAIL conflict_clear: got %b expected 0", bus_conflict);
      end
      @(negedge clk);
      rd_en = 1; #1;
      checks++;
      if (wbus !== 8'hA5) begin
         failures++;
         $display("FAIL conflict_keep: got %h expected a5", wbus);
      end
      rd_en = 0;
   endtask

   task automatic deposit(input logic [7:0] d, input logic [3:0] old_ptr,
                          input logic [3:0] new_ptr, input logic exp_wrap);
      @(negedge clk);
      prog_data = d; prog_strobe = 1;
      @(posedge clk);
      @(posedge clk); #1;
      checks++;
      if (prog_ptr !== old_ptr) begin
         failures++;
         $display("FAIL dep_early(%h): got ptr=%0d expected %0d", d, prog_ptr, old_ptr);
      end
      @(posedge clk); #1;
      checks++;
      if (prog_ptr !== new_ptr || prog_wrap !== exp_wrap) begin
         failures++;
         $display("FAIL dep_commit(%h): got ptr=%0d wrap=%b expected %0d %b",
                  d, prog_ptr, prog_wrap, new_ptr, exp_wrap);
      end
      @(negedge clk);
      prog_strobe = 0;
      @(posedge clk); #1;
      checks++;
      if (prog_wrap !== 1'b0) begin
         failures++;
         $display("FAIL wrap_width(%h): got %b expected 0", d, prog_wrap);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_prog;
      logic [7:0] exp [4];
      logic [3:0] rda [4];
      exp = '{8'h11, 8'h22, 8'h33, 8'h00};
      rda = '{4'd14, 4'd15, 4'd0, 4'd1};
      @(negedge clk);
      manual_mode = 1;
      @(negedge clk);
      prog_addr = 4'd14; prog_addr_ld = 1; rd_en = 1; tb_drv = 8'h3C; tb_drv_en = 1;
      @(negedge clk);
      prog_addr_ld = 0; rd_en = 0; #1;
      checks++;
      if (prog_ptr !== 4'd14 || wbus !== 8'h3C) begin
         failures++;
         $display("FAIL prog_load: got ptr=%0d wbus=%h expected 14 3c", prog_ptr, wbus);
      end
      tb_drv_en = 0;
      deposit(8'h11, 4'd14, 4'd15, 1'b0);
      deposit(8'h22, 4'd15, 4'd0,  1'b1);
      deposit(8'h33, 4'd0,  4'd1,  1'b0);
      @(negedge clk);
      manual_mode = 0;
      @(negedge clk);
      rd_en = 1;
      for (int i = 0; i < 4; i++) begin
         addr = rda[i]; #1;
         checks++;
         if (wbus !== exp[i]) begin
            failures++;
            $display("FAIL prog_readback[%0d]: got %h expected %h", rda[i], wbus, exp[i]);
         end
      end
      rd_en = 0;
   endtask

   task automatic test_held_strobe;
      @(negedge clk);
      prog_strobe = 1;
      repeat (2) @(negedge clk);
      prog_strobe = 0;
      repeat (4) @(negedge clk);
      manual_mode = 1;
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (prog_ptr !== 4'd1) begin
         failures++;
         $display("FAIL run_strobe_discard: got ptr=%0d expected 1", prog_ptr);
      end
      prog_data = 8'h44; prog_strobe = 1;
      repeat (10) @(negedge clk);
      prog_strobe = 0;
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (prog_ptr !== 4'd2) begin
         failures++;
         $display("FAIL held_strobe: got ptr=%0d expected 2", prog_ptr);
      end
      manual_mode = 0;
      @(negedge clk);
      rd_en = 1; addr = 4'd1; #1;
      checks++;
      if (wbus !== 8'h44) begin
         failures++;
         $display("FAIL held_data: got %h expected 44", wbus);
      end
      addr = 4'd2; #1;
      checks++;
      if (wbus !== 8'h00) begin
         failures++;
         $display("FAIL held_single: got %h expected 00", wbus);
      end
      rd_en = 0;
   endtask

   task automatic test_reset_mid_sweep;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1; #1;
      checks++;
      if (busy !== 1'b1 || prog_ptr !== 4'd0) begin
         failures++;
         $display("FAIL mid_reset: got busy=%b ptr=%0d expected 1 0", busy, prog_ptr);
      end
      @(negedge clk);
      rst = 0; #1;
      count_busy("sweep_restart");
      @(negedge clk);
      rd_en = 1; addr = 4'd14; #1;
      checks++;
      if (wbus !== 8'h00) begin
         failures++;
         $display("FAIL resweep_zero: got %h expected 00", wbus);
      end
      rd_en = 0;
   endtask

`ifdef SAP_MEM_PARITY_EN
   task automatic test_parity;
      @(negedge clk);
      dut.flip_parity(4'd5);
      @(negedge clk);
      addr = 4'd5; rd_en = 1;
      @(posedge clk); #1;
      checks++;
      if (parity_err !== 1'b1) begin
         failures++;
         $display("FAIL parity_bad: got %b expected 1", parity_err);
      end
      @(negedge clk);
      addr = 4'd4;
      @(posedge clk); #1;
      checks++;
      if (parity_err !== 1'b0) begin
         failures++;
         $display("FAIL parity_good: got %b expected 0", parity_err);
      end
      @(negedge clk);
      rd_en = 0;
   endtask
`endif

   initial begin
      test_reset;
      test_run_rw;
      test_conflict;
      test_prog;
      test_held_strobe;
      test_reset_mid_sweep;
`ifdef SAP_MEM_PARITY_EN
      test_parity;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
